thermal_governor: RTL and testbench

Closed-loop thermal controller that sits on the other side of the ASIC thermal model. It consumes the chip temperature and throttle flag, and produces the power request that drives the model. It decimates and averages temperature samples, runs a five-state thermal FSM with hysteresis, ramps the power request up or down in fixed steps, and drives fan PWM and shutdown/alarm indications.

---
 rtl/thermal_pkg.sv | 37 +++
 rtl/thermal_governor_if.sv | 24 ++
 rtl/temp_avg4.sv | 36 +++
 rtl/thermal_governor.sv | 151 +++++++++++++++
 tb/tb_thermal_governor.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/thermal_pkg.sv
// Shared thermal-control types and constants: state codes, fan duties, default thresholds.
// Pure declarations; no latency or backpressure of its own.
package thermal_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_NORMAL   = 3'd0;
  localparam state_t ST_WARN     = 3'd1;
  localparam state_t ST_THROTTLE = 3'd2;
  localparam state_t ST_SHUTDOWN = 3'd3;
  localparam state_t ST_COOLDOWN = 3'd4;

  localparam logic [7:0] FAN_NORMAL   = 8'h40;
  localparam logic [7:0] FAN_WARN     = 8'h80;
  localparam logic [7:0] FAN_THROTTLE = 8'hC0;
  localparam logic [7:0] FAN_FULL     = 8'hFF;

  localparam int unsigned DEF_SAMPLE_DIV  = 256;
  localparam logic [7:0]  DEF_T_WARN      = 8'd95;
  localparam logic [7:0]  DEF_T_THROTTLE  = 8'd110;
  localparam logic [7:0]  DEF_T_CRIT      = 8'd125;
  localparam logic [7:0]  DEF_HYST        = 8'd5;
  localparam logic [15:0] DEF_P_MIN       = 16'd700;
  localparam logic [15:0] DEF_P_MAX       = 16'd3000;
  localparam logic [15:0] DEF_P_STEP      = 16'd100;
  localparam logic [15:0] DEF_COOL_CYCLES = 16'd1024;

  function automatic logic [7:0] fan_duty(input state_t st);
    case (st)
      ST_NORMAL:   return FAN_NORMAL;
      ST_WARN:     return FAN_WARN;
      ST_THROTTLE: return FAN_THROTTLE;
      default:     return FAN_FULL;
    endcase
  endfunction

endpackage

// File: rtl/thermal_governor_if.sv
// Governor <-> thermal model signal bundle; master is the governor side.
// Plain wires, no latency; no backpressure (free-running control loop).
interface thermal_governor_if;
  import thermal_pkg::*;

  logic [7:0]  temperature;
  logic        throttle_request;
  logic [15:0] power_request;
  logic [7:0]  fan_pwm;
  state_t      state;
  logic        shutdown;
  logic        alarm;

  modport master (
    input  temperature, throttle_request,
    output power_request, fan_pwm, state, shutdown, alarm
  );

  modport slave (
    output temperature, throttle_request,
    input  power_request, fan_pwm, state, shutdown, alarm
  );

endinterface

// File: rtl/temp_avg4.sv
// Four-deep temperature window with truncating average; window updates on the sample edge,
// avg is combinational from the registered window. No backpressure.
module temp_avg4 (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic [7:0] temp_in,
  output logic [7:0] avg
);

  logic [7:0] w_q [4];
  logic [7:0] w_d [4];
  logic [9:0] sum;

  always_comb begin
    for (int i = 0; i < 4; i++) w_d[i] = w_q[i];
    if (sample_en) begin
      w_d[0] = temp_in;
      w_d[1] = w_q[0];
      w_d[2] = w_q[1];
      w_d[3] = w_q[2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) w_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) w_q[i] <= w_d[i];
    end
  end

  assign sum = {2'b00, w_q[0]} + {2'b00, w_q[1]} + {2'b00, w_q[2]} + {2'b00, w_q[3]};
  assign avg = 8'(sum >> 2);

endmodule

// File: rtl/thermal_governor.sv
// Closed-loop thermal governor: decimated averaging, 5-state FSM with hysteresis, power ramp, fan.
// Outputs update one edge after each sampling edge (cooldown expiry on any edge); no backpressure.
module thermal_governor import thermal_pkg::*; #(
  parameter int unsigned SAMPLE_DIV  = DEF_SAMPLE_DIV,
  parameter logic [7:0]  T_WARN      = DEF_T_WARN,
  parameter logic [7:0]  T_THROTTLE  = DEF_T_THROTTLE,
  parameter logic [7:0]  T_CRIT      = DEF_T_CRIT,
  parameter logic [7:0]  HYST        = DEF_HYST,
  parameter logic [15:0] P_MIN       = DEF_P_MIN,
  parameter logic [15:0] P_MAX       = DEF_P_MAX,
  parameter logic [15:0] P_STEP      = DEF_P_STEP,
  parameter logic [15:0] COOL_CYCLES = DEF_COOL_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  thermal_governor_if.master tif
);

  localparam int unsigned      DIV_W      = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [7:0]       WARN_EXIT  = T_WARN - HYST;
  localparam logic [7:0]       THR_EXIT   = T_THROTTLE - HYST;
  localparam logic [16:0]      DN_FLOOR   = {1'b0, P_MIN} + {1'b0, P_STEP};

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             sample_en;
  logic             thr_q, thr_d;
  logic             eval_en_q, eval_en_d;
  logic [7:0]       avg;

  state_t           state_q, state_d;
  logic [15:0]      cool_cnt_q, cool_cnt_d;
  logic [15:0]      power_q, power_d;
  logic [7:0]       fan_q, fan_d;
  logic             shutdown_q, shutdown_d;
  logic             alarm_q, alarm_d;

  logic             hot_crit, hot_thr, hot_warn, below_warn_exit, below_thr_exit;
  logic [16:0]      pr_up;

  assign sample_en = (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = sample_en ? '0 : div_cnt_q + 1'b1;
    thr_d     = sample_en ? tif.throttle_request : thr_q;
    eval_en_d = sample_en;
  end

  temp_avg4 u_avg (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .temp_in   (tif.temperature),
    .avg       (avg)
  );

  assign hot_crit        = (avg >= T_CRIT);
  assign hot_thr         = (avg >= T_THROTTLE);
  assign hot_warn        = (avg >= T_WARN);
  assign below_warn_exit = (avg < WARN_EXIT);
  assign below_thr_exit  = (avg < THR_EXIT);

  always_comb begin
    state_d    = state_q;
    cool_cnt_d = cool_cnt_q;
    case (state_q)
      ST_NORMAL: begin
        if (eval_en_q) begin
          if (hot_crit)                state_d = ST_SHUTDOWN;
          else if (hot_thr || thr_q)   state_d = ST_THROTTLE;
          else if (hot_warn)           state_d = ST_WARN;
        end
      end
      ST_WARN: begin
        if (eval_en_q) begin
          if (hot_crit)                state_d = ST_SHUTDOWN;
          else if (hot_thr || thr_q)   state_d = ST_THROTTLE;
          else if (below_warn_exit)    state_d = ST_NORMAL;
        end
      end
      ST_THROTTLE: begin
        if (eval_en_q) begin
          if (hot_crit)                       state_d = ST_SHUTDOWN;
          else if (below_thr_exit && !thr_q)  state_d = ST_WARN;
        end
      end
      ST_SHUTDOWN: begin
        if (eval_en_q && below_warn_exit) begin
          state_d    = ST_COOLDOWN;
          cool_cnt_d = COOL_CYCLES - 16'd1;
        end
      end
      ST_COOLDOWN: begin
        if (cool_cnt_q != 16'd0) cool_cnt_d = cool_cnt_q - 16'd1;
        // A re-heat abort outranks an expiry landing on the same edge.
        if (eval_en_q && (hot_crit || hot_thr)) state_d = ST_SHUTDOWN;
        else if (cool_cnt_q == 16'd0)           state_d = ST_NORMAL;
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  // 17-bit headroom keeps the saturating ramp from wrapping near full scale.
  assign pr_up = {1'b0, power_q} + {1'b0, P_STEP};

  always_comb begin
    power_d = power_q;
    if (eval_en_q) begin
      case (state_d)
        ST_NORMAL:   power_d = (pr_up > {1'b0, P_MAX}) ? P_MAX : pr_up[15:0];
        ST_WARN:     power_d = power_q;
        ST_THROTTLE: power_d = ({1'b0, power_q} < DN_FLOOR) ? P_MIN : power_q - P_STEP;
        default:     power_d = P_MIN;
      endcase
    end
    fan_d      = fan_duty(state_d);
    shutdown_d = (state_d == ST_SHUTDOWN);
    alarm_d    = (state_d == ST_SHUTDOWN) && (state_q != ST_SHUTDOWN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q  <= '0;
      thr_q      <= 1'b0;
      eval_en_q  <= 1'b0;
      state_q    <= ST_NORMAL;
      cool_cnt_q <= '0;
      power_q    <= P_MIN;
      fan_q      <= FAN_NORMAL;
      shutdown_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      thr_q      <= thr_d;
      eval_en_q  <= eval_en_d;
      state_q    <= state_d;
      cool_cnt_q <= cool_cnt_d;
      power_q    <= power_d;
      fan_q      <= fan_d;
      shutdown_q <= shutdown_d;
      alarm_q    <= alarm_d;
    end
  end

  assign tif.power_request = power_q;
  assign tif.fan_pwm       = fan_q;
  assign tif.state         = state_q;
  assign tif.shutdown      = shutdown_q;
  assign tif.alarm         = alarm_q;

endmodule

// File: tb/tb_thermal_governor.sv
// Bench for thermal_governor: directed scenarios plus random temperature/throttle traffic,
// every edge compared against an event-level reference model.
module tb_thermal_governor;
  import thermal_pkg::*;

  localparam int SD    = 4;
  localparam int CC    = 16;
  localparam int TW    = 95;
  localparam int TT    = 110;
  localparam int TC    = 125;
  localparam int HY    = 5;
  localparam int PMIN  = 700;
  localparam int PMAX  = 3000;
  localparam int PSTEP = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cur_temp = 8'd0;
  logic       cur_thr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int n_alarm  = 0;

  thermal_governor_if tif();
  assign tif.temperature      = cur_temp;
  assign tif.throttle_request = cur_thr;

  thermal_governor #(
    .SAMPLE_DIV  (SD),
    .COOL_CYCLES (16'd16)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .tif   (tif)
  );

  always #5 clk = ~clk;

  // Reference model: edge count since reset, sample queue, absolute cooldown deadline.
  int m_edge;
  int m_win[$];
  int m_thr;
  int m_eval;
  int m_state;
  int m_power;
  int m_alarm;
  int m_cool_end;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int fan_of(input int s);
    case (s)
      0:       return 'h40;
      1:       return 'h80;
      2:       return 'hC0;
      default: return 'hFF;
    endcase
  endfunction

  task automatic model_edge();
    int prev, nxt, avg;
    if (rst) begin
      m_edge = 0; m_win = '{0, 0, 0, 0}; m_thr = 0; m_eval = 0;
      m_state = 0; m_power = PMIN; m_alarm = 0; m_cool_end = -1;
      return;
    end
    m_edge++;
    prev = m_state;
    nxt  = prev;
    if (m_eval != 0) begin
      avg = (m_win[0] + m_win[1] + m_win[2] + m_win[3]) / 4;
      case (prev)
        0: if (avg >= TC) nxt = 3; else if (avg >= TT || m_thr != 0) nxt = 2; else if (avg >= TW) nxt = 1;
        1: if (avg >= TC) nxt = 3; else if (avg >= TT || m_thr != 0) nxt = 2; else if (avg < TW - HY) nxt = 0;
        2: if (avg >= TC) nxt = 3; else if (avg < TT - HY && m_thr == 0) nxt = 1;
        3: if (avg < TW - HY) nxt = 4;
        default: if (avg >= TT) nxt = 3;
      endcase
    end
    if (prev == 4 && nxt == 4 && m_edge == m_cool_end) nxt = 0;
    if (nxt == 4 && prev != 4) m_cool_end = m_edge + CC;
    if (m_eval != 0) begin
      case (nxt)
        0:       m_power = (m_power + PSTEP > PMAX) ? PMAX : m_power + PSTEP;
        1:       m_power = m_power;
        2:       m_power = (m_power - PSTEP < PMIN) ? PMIN : m_power - PSTEP;
        default: m_power = PMIN;
      endcase
    end
    m_alarm = (nxt == 3 && prev != 3) ? 1 : 0;
    m_state = nxt;
    m_eval  = (m_edge % SD == 0) ? 1 : 0;
    if (m_eval != 0) begin
      m_win.push_front(int'(cur_temp));
      void'(m_win.pop_back());
      m_thr = int'(cur_thr);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("state", int'(tif.state), m_state);
    check_eq("power", int'(tif.power_request), m_power);
    check_eq("fan", int'(tif.fan_pwm), fan_of(m_state));
    check_eq("shutdown", int'(tif.shutdown), (m_state == 3) ? 1 : 0);
    check_eq("alarm", int'(tif.alarm), m_alarm);
    n_alarm += int'(tif.alarm);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    int a0, seg, lvl;

    // Reset values
    cur_temp = 8'd60; cur_thr = 1'b0;
    do_reset();
    check_eq("rst_state", int'(tif.state), int'(ST_NORMAL));
    check_eq("rst_power", int'(tif.power_request), 700);
    check_eq("rst_fan", int'(tif.fan_pwm), 'h40);
    check_eq("rst_shutdown", int'(tif.shutdown), 0);
    check_eq("rst_alarm", int'(tif.alarm), 0);

    // Ramp up to saturation at constant 60 C
    run(5);
    check_eq("ramp_first", int'(tif.power_request), 800);
    run(4 * 21);
    check_eq("ramp_22", int'(tif.power_request), 2900);
    run(4);
    check_eq("ramp_sat", int'(tif.power_request), 3000);
    run(20);
    check_eq("ramp_hold", int'(tif.power_request), 3000);
    check_eq("ramp_fan", int'(tif.fan_pwm), 'h40);

    // Warn entry and hysteretic exit
    cur_temp = 8'd100;
    do_reset();
    run(17);
    check_eq("warn_state", int'(tif.state), int'(ST_WARN));
    check_eq("warn_fan", int'(tif.fan_pwm), 'h80);
    check_eq("warn_power", int'(tif.power_request), 1000);
    cur_temp = 8'd80;
    run(8);
    check_eq("warn_hyst_edge", int'(tif.state), int'(ST_WARN));
    run(4);
    check_eq("warn_exit", int'(tif.state), int'(ST_NORMAL));
    check_eq("warn_exit_power", int'(tif.power_request), 1100);

    // Shutdown and cooldown recovery
    cur_temp = 8'd130;
    do_reset();
    a0 = n_alarm;
    run(13);
    check_eq("sd_pre_warn", int'(tif.state), int'(ST_WARN));
    run(4);
    check_eq("sd_state", int'(tif.state), int'(ST_SHUTDOWN));
    check_eq("sd_alarm", int'(tif.alarm), 1);
    check_eq("sd_shutdown", int'(tif.shutdown), 1);
    check_eq("sd_power", int'(tif.power_request), 700);
    check_eq("sd_fan", int'(tif.fan_pwm), 'hFF);
    run(1);
    check_eq("sd_alarm_pulse", int'(tif.alarm), 0);
    cur_temp = 8'd60;
    run(11);
    check_eq("cool_entry", int'(tif.state), int'(ST_COOLDOWN));
    check_eq("cool_shutdown", int'(tif.shutdown), 0);
    run(15);
    check_eq("cool_hold", int'(tif.state), int'(ST_COOLDOWN));
    run(1);
    check_eq("cool_expire", int'(tif.state), int'(ST_NORMAL));
    check_eq("sd_alarm_count", n_alarm - a0, 1);

    // Throttle input drives power down to the floor
    cur_temp = 8'd60; cur_thr = 1'b0;
    do_reset();
    run(13);
    check_eq("thr_start_power", int'(tif.power_request), 1000);
    cur_thr = 1'b1;
    run(4);
    check_eq("thr_state", int'(tif.state), int'(ST_THROTTLE));
    check_eq("thr_power1", int'(tif.power_request), 900);
    run(8);
    check_eq("thr_floor", int'(tif.power_request), 700);
    run(8);
    check_eq("thr_floor_hold", int'(tif.power_request), 700);
    check_eq("thr_fan", int'(tif.fan_pwm), 'hC0);
    cur_thr = 1'b0;
    run(4);
    check_eq("thr_release_warn", int'(tif.state), int'(ST_WARN));
    run(4);
    check_eq("thr_release_normal", int'(tif.state), int'(ST_NORMAL));

    // Cooldown abort on re-heat, coinciding with expiry edge
    cur_temp = 8'd130;
    do_reset();
    a0 = n_alarm;
    run(17);
    cur_temp = 8'd60;
    run(12);
    check_eq("abort_cool", int'(tif.state), int'(ST_COOLDOWN));
    cur_temp = 8'd120;
    run(15);
    check_eq("abort_pre", int'(tif.state), int'(ST_COOLDOWN));
    run(1);
    check_eq("abort_state", int'(tif.state), int'(ST_SHUTDOWN));
    check_eq("abort_alarm", int'(tif.alarm), 1);
    check_eq("abort_alarm_count", n_alarm - a0, 2);

    // Reset while throttling
    cur_temp = 8'd60; cur_thr = 1'b1;
    do_reset();
    run(9);
    check_eq("mid_thr_state", int'(tif.state), int'(ST_THROTTLE));
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    check_eq("mid_rst_state", int'(tif.state), 0);
    check_eq("mid_rst_power", int'(tif.power_request), 700);
    check_eq("mid_rst_fan", int'(tif.fan_pwm), 'h40);
    check_eq("mid_rst_alarm", int'(tif.alarm), 0);
    check_eq("mid_rst_shutdown", int'(tif.shutdown), 0);

    // Random traffic against the model
    cur_thr = 1'b0;
    for (int s = 0; s < 120; s++) begin
      lvl = int'($urandom_range(20, 160));
      seg = int'($urandom_range(4, 48));
      cur_temp = 8'(lvl);
      cur_thr  = ($urandom_range(0, 4) == 0);
      for (int c = 0; c < seg; c++) begin
        rst = ($urandom_range(0, 399) == 0);
        tick();
        if (c % 7 == 3) cur_temp = 8'(lvl + int'($urandom_range(0, 6)) - 3);
      end
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
